// File: rtl/ras_replay_buffer.sv
// Replay buffer beside the fetch-stage return-address stack: logs popped return
// addresses and, after a flush, pushes wrong-path pops back youngest-first.

package ras_replay_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
  } ras_t;
endpackage

module ras_replay_buffer
  import ras_replay_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pop_valid_i,
  input  logic [XLEN-1:0] pop_data_i,
  input  logic            resolve_i,
  input  logic            flush_i,
  input  logic [CW-1:0]   flush_keep_i,
  output ras_t            restore_o,
  output logic            busy_o,
  output logic            full_o,
  output logic [CW-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, REPLAY = 1'b1} state_t;

  // Handshake: pops and resolves are single-cycle pulses with no back-pressure;
  // fetch must not pop while busy_o is high, and restore_o.valid is a one-cycle
  // strobe the stack consumes unconditionally.

  state_t          state;
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   tgt;

  logic            res_eff;
  logic            evict;
  logic            replay_go;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   tgt_r;
  logic [CW-1:0]   tgt_n;
  logic [AW-1:0]   head_r;
  logic [AW-1:0]   tail_m1;

  // Resolve is always applied before flush/replay decisions in the same cycle.
  always_comb begin
    res_eff = resolve_i && (count != '0);
    cnt_r   = count - CW'(res_eff);
    head_r  = head + AW'(res_eff);
    tgt_r   = (res_eff && (tgt != '0)) ? tgt - CW'(1) : tgt;
    tgt_n   = tgt_r;
    if (state == IDLE) begin
      tgt_n = (flush_keep_i < cnt_r) ? flush_keep_i : cnt_r;
    end else if (flush_i && (flush_keep_i < tgt_r)) begin
      tgt_n = flush_keep_i;
    end
    replay_go = ((state == REPLAY) || flush_i) && (cnt_r > tgt_n);
    tail_m1   = tail - AW'(1);
    evict     = pop_valid_i && !res_eff && (count == CW'(DEPTH));
  end

  // The first replayed entry is launched on the flush edge itself, so the
  // youngest address reaches the stack the cycle after the flush. REPLAY holds
  // for every cycle an entry is on restore_o, which keeps busy_o aligned with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      tgt       <= '0;
      restore_o <= '0;
    end else begin
      restore_o <= '0;
      head      <= head_r;
      case (state)
        IDLE: begin
          if (flush_i) begin
            tgt   <= tgt_n;
            count <= cnt_r;
            if (replay_go) begin
              restore_o <= '{valid: 1'b1, data: mem[tail_m1]};
              tail      <= tail_m1;
              count     <= cnt_r - CW'(1);
              state     <= REPLAY;
            end
          end else begin
            if (pop_valid_i) begin
              tail <= tail + AW'(1);
            end
            head  <= head_r + AW'(evict);
            count <= cnt_r + CW'(pop_valid_i && !evict);
          end
        end
        REPLAY: begin
          tgt <= tgt_n;
          if (replay_go) begin
            restore_o <= '{valid: 1'b1, data: mem[tail_m1]};
            tail      <= tail_m1;
            count     <= cnt_r - CW'(1);
          end else begin
            count <= cnt_r;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; only slots between head and tail are ever read.
  always_ff @(posedge clk_i) begin
    if ((state == IDLE) && !flush_i && pop_valid_i) begin
      mem[tail] <= pop_data_i;
    end
  end

  // busy_o doubles as the FSM state observation point.
  assign busy_o  = (state == REPLAY);
  assign full_o  = (count == CW'(DEPTH));
  assign count_o = count;

endmodule
